// File: rtl/apb_ram_pkg.sv
// Shared types and default sizes for the APB RAM completer and its helpers.
package apb_ram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_W = 4;
  localparam int APB_DATA_W = 8;
  localparam int APB_DEPTH  = 16;

endpackage

// File: rtl/apb_ram_completer_if.sv
// APB3 bus bundle between one requester and one completer select line.
// Handshake: a transfer opens with psel=1, penable=0 for one cycle, then penable=1 is held
// with all request fields stable until the completer drives pready=1; prdata/pslverr are
// meaningful only in that pready cycle, and the requester may drop psel only afterwards.
interface apb_ram_completer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_wait_ctr.sv
// Wait-state down-counter: load a count, step down to zero, report when zero.
module apb_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/apb_ram_completer.sv
// APB3 completer in front of a byte-wide RAM with programmable wait states and error flagging.
module apb_ram_completer
  import apb_ram_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = APB_DEPTH,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  apb_ram_completer_if.slave  bus,
  output apb_state_t          dbg_state
);
  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              dir_q, err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic latch, ctr_clear, ctr_load, ctr_dec, ctr_zero;
  logic req, req_err, pready, write_en;

  // A new request is the bus SETUP phase; its error status is decided once, here.
  assign req     = bus.psel && !bus.penable;
  assign req_err = (int'(bus.paddr) >= DEPTH) || $isunknown(bus.paddr) ||
                   (bus.pwrite && $isunknown(bus.pwdata));

  apb_wait_ctr #(.W(4)) u_wait_ctr (
    .clk      (pclk),
    .rst      (preset),
    .clear    (ctr_clear),
    .load     (ctr_load),
    .load_val (4'(WAIT_CYCLES)),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    ctr_clear = 1'b0;
    ctr_load  = 1'b0;
    ctr_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          latch   = 1'b1;
        end
      end
      SETUP: begin
        if (!bus.psel) begin
          state_d   = IDLE;
          ctr_clear = 1'b1;
        end else begin
          state_d  = ACCESS;
          ctr_load = 1'b1;
        end
      end
      ACCESS: begin
        if (ctr_zero) begin
          if (req) begin
            state_d = SETUP;
            latch   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!bus.psel) begin
          state_d   = IDLE;
          ctr_clear = 1'b1;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pready   = (state_q == ACCESS) && ctr_zero;
  assign write_en = pready && dir_q && !err_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q <= bus.paddr;
        data_q <= bus.pwdata;
        dir_q  <= bus.pwrite;
        err_q  <= req_err;
      end
      // Uses the request being completed; a back-to-back latch updates addr_q only afterwards.
      if (write_en) mem[addr_q] <= data_q;
    end
  end

  assign bus.pready  = pready;
  assign bus.pslverr = pready && err_q;
  assign bus.prdata  = (pready && !dir_q && !err_q) ? mem[addr_q] : '0;
  assign dbg_state   = state_q;
endmodule
